// File: rtl/jts16_trackball_rdctl.sv
// CPU read window over eight 12-bit trackball counters, with coherent low/high byte reads.
// Optional macro TRACKBALL_DELTA_EN: reads return the counter minus a per-channel reference.
module jts16_trackball_rdctl #(
   parameter int STALE_LINES = 4
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        LHBL,
   input  logic        cs,
   input  logic        rnw,
   input  logic [3:0]  addr,
   input  logic [7:0]  din,
   input  logic [95:0] trackball,
   output logic [7:0]  dout,
   output logic        ok
);
   typedef enum logic {IDLE = 1'b0, HELD = 1'b1} ch_state_t;

   localparam logic [3:0] STALE = 4'(STALE_LINES);
`ifdef TRACKBALL_DELTA_EN
   localparam int SNAP_W = 12;
`else
   localparam int SNAP_W = 4;
`endif

   logic        cs_l, lhbl_l, armed_reg;
   logic        start, tick, rd_lo, rd_hi;
   logic [2:0]  ch;
   logic [7:0]  held_vec;
   logic [11:0] val [8];
   logic [3:0]  snap_nib [8];
   logic [11:0] cur;
   logic [3:0]  hi_nib;
   logic        unused_din;

   // armed_reg keeps a cs that is still high after reset from being taken as a new access
   assign ch     = addr[3:1];
   assign start  = cs & ~cs_l & armed_reg;
   assign tick   = lhbl_l & ~LHBL;
   assign rd_lo  = start & rnw & ~addr[0];
   assign rd_hi  = start & rnw & addr[0];
   assign cur    = val[ch];
   assign hi_nib = held_vec[ch] ? snap_nib[ch] : cur[11:8];
   assign unused_din = ^din;

`ifdef TRACKBALL_DELTA_EN
   logic wr;
   assign wr = start & ~rnw;
`endif

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_ch
         ch_state_t         state_reg, state_next;
         logic [3:0]        cnt_reg, cnt_next;
         logic [SNAP_W-1:0] snap_reg;
         logic              sel;

         assign sel = (ch == 3'(gi));

`ifdef TRACKBALL_DELTA_EN
         logic [11:0] ref_reg;
         assign val[gi] = trackball[12*gi +: 12] - ref_reg;

         always_ff @(posedge clk) begin
            if (!rst_n)
               ref_reg <= '0;
            else if (sel && wr)
               ref_reg <= trackball[12*gi +: 12];
            else if (sel && rd_hi && state_reg == HELD)
               ref_reg <= ref_reg + snap_reg;
         end
`else
         assign val[gi] = trackball[12*gi +: 12];
`endif

         assign held_vec[gi] = (state_reg == HELD);
         assign snap_nib[gi] = snap_reg[SNAP_W-1 -: 4];

         // Accesses to this channel take priority over a coincident line tick
         always_comb begin
            state_next = state_reg;
            cnt_next   = cnt_reg;
            if (sel && rd_lo) begin
               state_next = HELD;
               cnt_next   = '0;
            end else if (sel && rd_hi) begin
               state_next = IDLE;
`ifdef TRACKBALL_DELTA_EN
            end else if (sel && wr && din[0]) begin
               state_next = IDLE;
`endif
            end else if (tick && state_reg == HELD) begin
               if (cnt_reg + 4'd1 >= STALE) begin
                  state_next = IDLE;
                  cnt_next   = STALE;
               end else begin
                  cnt_next = cnt_reg + 4'd1;
               end
            end
         end

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               state_reg <= IDLE;
               cnt_reg   <= '0;
               snap_reg  <= '0;
            end else begin
               state_reg <= state_next;
               cnt_reg   <= cnt_next;
               if (sel && rd_lo)
                  snap_reg <= val[gi][11 -: SNAP_W];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cs_l      <= 1'b0;
         lhbl_l    <= 1'b0;
         armed_reg <= 1'b0;
         ok        <= 1'b0;
         dout      <= '0;
      end else begin
         cs_l      <= cs;
         lhbl_l    <= LHBL;
         armed_reg <= armed_reg | ~cs;
         ok        <= start | (ok & cs);
         if (rd_lo)
            dout <= cur[7:0];
         else if (rd_hi)
            dout <= {{4{hi_nib[3]}}, hi_nib};
      end
   end

endmodule

// File: tb/tb_jts16_trackball_rdctl.sv
// Scoreboard bench for jts16_trackball_rdctl: directed cases plus randomized accesses.
module tb_jts16_trackball_rdctl;
   localparam int STALE = 4;

   logic        clk = 1'b0;
   logic        rst_n, LHBL, cs, rnw;
   logic [3:0]  addr;
   logic [7:0]  din;
   logic [95:0] trackball;
   logic [7:0]  dout;
   logic        ok;

   int checks = 0;
   int errors = 0;

   jts16_trackball_rdctl #(.STALE_LINES(STALE)) dut (
      .clk(clk), .rst_n(rst_n), .LHBL(LHBL), .cs(cs), .rnw(rnw), .addr(addr),
      .din(din), .trackball(trackball), .dout(dout), .ok(ok)
   );

   always #5 clk = ~clk;

   typedef struct { logic [7:0] d; int len; } exp_t;
   exp_t q[$];

   // reference model: per-channel snapshot state, kept as plain arrays
   bit          m_held [8];
   logic [11:0] m_snap [8];
   int          m_age  [8];
   logic [11:0] m_ref  [8];
   logic [7:0]  m_dout;

   task automatic check(string name, int act, int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] sext(logic [3:0] n);
      return {{4{n[3]}}, n};
   endfunction

   function automatic logic [11:0] get_ch(int c);
      return trackball[12*c +: 12];
   endfunction

   function automatic logic [11:0] mval(int c);
`ifdef TRACKBALL_DELTA_EN
      return get_ch(c) - m_ref[c];
`else
      return get_ch(c);
`endif
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 8; i++) begin
         m_held[i] = 0; m_snap[i] = '0; m_age[i] = 0; m_ref[i] = '0;
      end
      m_dout = '0;
   endfunction

   function automatic void model_tick(int excl);
      for (int i = 0; i < 8; i++)
         if (i != excl && m_held[i]) begin
            m_age[i]++;
            if (m_age[i] >= STALE) m_held[i] = 0;
         end
   endfunction

   function automatic logic [7:0] model_access(bit rd, logic [3:0] a, logic [7:0] wd, bit with_tick);
      int c = int'(a[3:1]);
      logic [11:0] v, s;
      if (rd) begin
         if (!a[0]) begin
            v = mval(c);
            m_dout = v[7:0];
            m_held[c] = 1; m_snap[c] = v; m_age[c] = 0;
         end else if (m_held[c]) begin
            s = m_snap[c];
            m_dout = sext(s[11:8]);
            m_held[c] = 0;
`ifdef TRACKBALL_DELTA_EN
            m_ref[c] = m_ref[c] + s;
`endif
         end else begin
            v = mval(c);
            m_dout = sext(v[11:8]);
         end
      end else begin
`ifdef TRACKBALL_DELTA_EN
         m_ref[c] = get_ch(c);
         if (wd[0]) m_held[c] = 0;
`endif
      end
      if (with_tick) model_tick(rd ? c : -1);
      return m_dout;
   endfunction

   task automatic set_ch(int c, logic [11:0] v);
      trackball[12*c +: 12] = v;
   endtask

   // called at posedge+1 with cs low; holds cs for len clocks
   task automatic access(bit rd, logic [3:0] a, logic [7:0] wd, int len, bit with_tick);
      exp_t e;
      e.d = model_access(rd, a, wd, with_tick);
      e.len = len;
      q.push_back(e);
      cs = 1'b1; rnw = rd; addr = a; din = wd;
      if (with_tick) LHBL = 1'b0;
      @(posedge clk); #1;
      LHBL = 1'b1;
      repeat (len - 1) begin @(posedge clk); #1; end
      cs = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic line_tick();
      model_tick(-1);
      LHBL = 1'b0;
      @(posedge clk); #1;
      LHBL = 1'b1;
      @(posedge clk); #1;
   endtask

   // monitor: pops one expectation per ok pulse, checks dout then pulse length
   bit   ok_prev = 0;
   bit   have_cur = 0;
   int   run = 0;
   exp_t cur;
   always @(negedge clk) begin
      if (ok) begin
         if (!ok_prev) begin
            if (q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_ok: got ok=1 expected no access at %0t", $time);
               have_cur = 0;
            end else begin
               cur = q.pop_front();
               have_cur = 1;
               run = 1;
               check("dout", int'(dout), int'(cur.d));
            end
         end else begin
            run++;
         end
      end else if (ok_prev && have_cur) begin
         check("ok_len", run, cur.len);
         have_cur = 0;
      end
      ok_prev = ok;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] a;
      int r, c, len;
      rst_n = 1'b0; LHBL = 1'b1; cs = 1'b0; rnw = 1'b1; addr = '0; din = '0; trackball = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_ok", int'(ok), 0);
      check("reset_dout", int'(dout), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // coherent two-byte read
      set_ch(0, 12'h10A);
      access(1, 4'h0, 8'h00, 1, 0);
      set_ch(0, 12'h2FF);
      access(1, 4'h1, 8'h00, 1, 0);
      // sign-extended live read
      set_ch(3, 12'h9C4);
      access(1, 4'h7, 8'h00, 2, 0);
      // expiry after STALE ticks, and survival after STALE-1
      set_ch(1, 12'h20B);
      access(1, 4'h2, 8'h00, 1, 0);
      repeat (4) line_tick();
      set_ch(1, 12'h30B);
      access(1, 4'h3, 8'h00, 1, 0);
      set_ch(1, 12'h20B);
      access(1, 4'h2, 8'h00, 1, 0);
      repeat (3) line_tick();
      set_ch(1, 12'h30B);
      access(1, 4'h3, 8'h00, 1, 0);
      // low read coincident with a tick; a parallel held channel expires
      set_ch(5, 12'h512); set_ch(6, 12'h634);
      access(1, 4'hC, 8'h00, 1, 0);
      access(1, 4'hA, 8'h00, 1, 0);
      repeat (3) line_tick();
      access(1, 4'hA, 8'h00, 1, 1);
      set_ch(6, 12'h7FF);
      access(1, 4'hD, 8'h00, 1, 0);
      repeat (3) line_tick();
      set_ch(5, 12'hE00);
      access(1, 4'hB, 8'h00, 1, 0);
      // high read coincident with a tick that would expire the snapshot
      set_ch(4, 12'hA55);
      access(1, 4'h8, 8'h00, 1, 0);
      repeat (3) line_tick();
      set_ch(4, 12'h155);
      access(1, 4'h9, 8'h00, 1, 1);
      // long and write handshakes
      access(1, 4'hE, 8'h00, 10, 0);
      access(0, 4'h4, 8'h00, 3, 0);

`ifdef TRACKBALL_DELTA_EN
      set_ch(0, 12'h100);
      access(0, 4'h0, 8'h00, 1, 0);
      set_ch(0, 12'h105);
      access(1, 4'h0, 8'h00, 1, 0);
      access(1, 4'h1, 8'h00, 1, 0);
      access(1, 4'h0, 8'h00, 1, 0);
`endif

      // reset in the middle of an access with cs held high
      set_ch(2, 12'h3C1);
      access(1, 4'h4, 8'h00, 1, 0);
      set_ch(2, 12'hC3C);
      q.push_back('{d: model_access(1, 4'h9, 8'h00, 0), len: 1});
      cs = 1'b1; rnw = 1'b1; addr = 4'h9;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      model_reset();
      check("midreset_ok", int'(ok), 0);
      check("midreset_dout", int'(dout), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
         check("no_access_after_reset", int'(ok), 0);
      end
      cs = 1'b0;
      @(posedge clk); #1;
      access(1, 4'h5, 8'h00, 1, 0);
      access(1, 4'h1, 8'h00, 1, 0);

      // randomized traffic
      for (int i = 0; i < 200; i++) begin
         c = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 2) : $urandom_range(0, 7);
         if ($urandom_range(0, 1) == 1) set_ch(c, 12'($urandom));
         r = $urandom_range(0, 9);
         len = $urandom_range(1, 3);
         a = {3'(c), 1'b0};
         if (r < 4)       access(1, a, 8'h00, len, 0);
         else if (r < 7)  access(1, a | 4'h1, 8'h00, len, 0);
         else if (r == 7) access(0, 4'($urandom), 8'($urandom), len, 0);
         else if (r == 8) line_tick();
         else             access(1, a | 4'($urandom_range(0, 1)), 8'h00, len, 1);
      end

      repeat (5) @(posedge clk);
      #1;
      check("queue_drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
